// File: rtl/kmeans_manhattan.sv
// Sequential K-means colour clusterer (Manhattan distance) over a streamed RGB image.
// Define KMEANS_EARLY_EXIT_EN to stop as soon as an UPDATE pass leaves every centroid unchanged.
module kmeans_manhattan #(
  parameter int unsigned data_size = 10000,
  parameter int unsigned MAX_ITER  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] Sin,
  output logic        strb
);

  localparam int unsigned SW = $clog2(data_size);
  localparam int unsigned DW = 8 + SW;
  localparam int unsigned CW = SW + 1;
  localparam int unsigned TW = $clog2(DW + 1);
  localparam int unsigned IW = $clog2(MAX_ITER + 1);

  typedef enum logic [2:0] {
    S_WAIT, S_CONFIG, S_LOAD, S_INIT, S_ASSIGN, S_UPDATE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SW-1:0]        size_q, size_d;
  logic [4:0]           k_q, k_d;
  logic [SW-1:0]        idx_q, idx_d;
  logic [3:0]           cj_q, cj_d;
  logic [1:0]           ch_q, ch_d;
  logic [TW-1:0]        step_q, step_d;
  logic [9:0]           best_d_q, best_d_d;
  logic [3:0]           best_j_q, best_j_d;
  logic [CW-1:0]        rem_q, rem_d;
  logic [DW-1:0]        quo_q, quo_d;
  logic                 changed_q, changed_d;
  logic [IW-1:0]        iter_q, iter_d;
  logic                 strb_q, strb_d;
  logic [2:0][7:0]      cen_q [16];
  logic [2:0][7:0]      cen_d [16];
  logic [2:0][DW-1:0]   sum_q [16];
  logic [2:0][DW-1:0]   sum_d [16];
  logic [CW-1:0]        cnt_q [16];
  logic [CW-1:0]        cnt_d [16];

  logic [2:0][7:0]      pix_mem_q   [data_size];
  logic [3:0]           label_mem_q [data_size];
  logic                 pix_we_c, lbl_we_c;

  logic [SW-1:0]        cfg_size_c, init_idx_c;
  logic [3:0]           cfg_kf_c, win_j_c;
  logic                 k_last_c, pix_last_c, better_c;
  logic [2:0][7:0]      pix_c, cen_c;
  logic [9:0]           dist_c;
  logic [CW:0]          div_c, shl_c;
  logic                 ge_c, step_zero_c, div_last_c, cnt_zero_c, ch_diff_c;
  logic [CW-1:0]        rem_n_c;
  logic [DW-1:0]        quo_n_c;
  logic                 changed_c, clus_end_c, upd_fin_c, early_exit_c, stop_c;
  logic [IW-1:0]        iter_inc_c;
  logic                 sin_unused_c;
  logic [3:0]           label_unused_c;

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Config decode, loop bounds and distance to the centroid currently being scanned
  assign cfg_kf_c     = Sin[SW+3:SW];
  assign cfg_size_c   = (32'(Sin[SW-1:0]) > data_size) ? SW'(data_size) : Sin[SW-1:0];
  assign sin_unused_c = ^Sin[23:SW+4];
  assign k_last_c     = (5'(cj_q) == k_q - 5'd1);
  assign pix_last_c   = (idx_q == size_q - SW'(1));
  assign pix_c        = pix_mem_q[idx_q];
  assign cen_c        = cen_q[cj_q];
  assign init_idx_c   = (SW'(cj_q) < size_q) ? SW'(cj_q) : size_q - SW'(1);
  assign dist_c       = 10'(absdiff(pix_c[0], cen_c[0])) + 10'(absdiff(pix_c[1], cen_c[1]))
                      + 10'(absdiff(pix_c[2], cen_c[2]));
  assign better_c     = (cj_q == 4'd0) || (dist_c < best_d_q);
  assign win_j_c      = better_c ? cj_q : best_j_q;
  // Labels are only consumed by hierarchical readout; this read keeps the array referenced
  assign label_unused_c = label_mem_q[idx_q];

  // One restoring-division step per cycle: quo holds the shifting dividend/quotient
  assign div_c       = {1'b0, cnt_q[cj_q]};
  assign shl_c       = {rem_q, quo_q[DW-1]};
  assign ge_c        = (shl_c >= div_c);
  assign rem_n_c     = ge_c ? CW'(shl_c - div_c) : shl_c[CW-1:0];
  assign quo_n_c     = {quo_q[DW-2:0], ge_c};
  assign step_zero_c = (step_q == '0);
  assign div_last_c  = (step_q == TW'(DW));
  assign cnt_zero_c  = (cnt_q[cj_q] == '0);
  assign ch_diff_c   = (quo_n_c[7:0] != cen_c[ch_q]);
  assign changed_c   = changed_q | (div_last_c & ch_diff_c);
  assign clus_end_c  = (step_zero_c & cnt_zero_c) | (div_last_c & (ch_q == 2'd2));
  assign upd_fin_c   = (state_q == S_UPDATE) & clus_end_c & k_last_c;
  assign iter_inc_c  = iter_q + IW'(1);
`ifdef KMEANS_EARLY_EXIT_EN
  assign early_exit_c = ~changed_c;
`else
  assign early_exit_c = 1'b0;
`endif
  assign stop_c      = (iter_inc_c == IW'(MAX_ITER)) | early_exit_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_WAIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   state_d = S_CONFIG;
      S_CONFIG: state_d = (cfg_size_c == '0) ? S_DONE : S_LOAD;
      S_LOAD:   if (pix_last_c) state_d = S_INIT;
      S_INIT:   if (k_last_c) state_d = S_ASSIGN;
      S_ASSIGN: if (k_last_c && pix_last_c) state_d = S_UPDATE;
      S_UPDATE: if (upd_fin_c) state_d = stop_c ? S_DONE : S_ASSIGN;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_WAIT;
    endcase
  end

  always_comb begin
    size_d    = size_q;
    k_d       = k_q;
    idx_d     = idx_q;
    cj_d      = cj_q;
    ch_d      = ch_q;
    step_d    = step_q;
    best_d_d  = best_d_q;
    best_j_d  = best_j_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    changed_d = changed_q;
    iter_d    = iter_q;
    cen_d     = cen_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    pix_we_c  = 1'b0;
    lbl_we_c  = 1'b0;
    strb_d    = (state_d == S_DONE);
    case (state_q)
      S_CONFIG: begin
        size_d = cfg_size_c;
        k_d    = (cfg_kf_c == 4'd0) ? 5'd16 : 5'(cfg_kf_c);
        idx_d  = '0;
        cj_d   = '0;
      end
      S_LOAD: begin
        pix_we_c = ~reset;
        idx_d    = pix_last_c ? '0 : idx_q + SW'(1);
      end
      S_INIT: begin
        cen_d[cj_q] = pix_mem_q[init_idx_c];
        cj_d        = k_last_c ? 4'd0 : cj_q + 4'd1;
        iter_d      = '0;
        changed_d   = 1'b0;
        for (int j = 0; j < 16; j++) begin
          sum_d[j] = '0;
          cnt_d[j] = '0;
        end
      end
      S_ASSIGN: begin
        best_d_d = better_c ? dist_c : best_d_q;
        best_j_d = win_j_c;
        if (k_last_c) begin
          lbl_we_c = ~reset;
          for (int c = 0; c < 3; c++)
            sum_d[win_j_c][c] = sum_q[win_j_c][c] + DW'(pix_c[c]);
          cnt_d[win_j_c] = cnt_q[win_j_c] + CW'(1);
          cj_d           = 4'd0;
          idx_d          = pix_last_c ? '0 : idx_q + SW'(1);
          ch_d           = 2'd0;
          step_d         = '0;
        end else begin
          cj_d = cj_q + 4'd1;
        end
      end
      S_UPDATE: begin
        if (step_zero_c) begin
          if (cnt_zero_c) begin
            ch_d = 2'd0;
            cj_d = k_last_c ? 4'd0 : cj_q + 4'd1;
          end else begin
            rem_d  = '0;
            quo_d  = sum_q[cj_q][ch_q];
            step_d = TW'(1);
          end
        end else begin
          rem_d  = rem_n_c;
          quo_d  = quo_n_c;
          step_d = step_q + TW'(1);
          if (div_last_c) begin
            cen_d[cj_q][ch_q] = quo_n_c[7:0];
            changed_d         = changed_c;
            step_d            = '0;
            if (ch_q == 2'd2) begin
              ch_d = 2'd0;
              cj_d = k_last_c ? 4'd0 : cj_q + 4'd1;
            end else begin
              ch_d = ch_q + 2'd1;
            end
          end
        end
        if (upd_fin_c) begin
          iter_d    = iter_inc_c;
          changed_d = 1'b0;
          idx_d     = '0;
          for (int j = 0; j < 16; j++) begin
            sum_d[j] = '0;
            cnt_d[j] = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      size_q    <= '0;
      k_q       <= '0;
      idx_q     <= '0;
      cj_q      <= '0;
      ch_q      <= '0;
      step_q    <= '0;
      best_d_q  <= '0;
      best_j_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      changed_q <= 1'b0;
      iter_q    <= '0;
      strb_q    <= 1'b0;
      cen_q     <= '{default: '0};
      sum_q     <= '{default: '0};
      cnt_q     <= '{default: '0};
    end else begin
      size_q    <= size_d;
      k_q       <= k_d;
      idx_q     <= idx_d;
      cj_q      <= cj_d;
      ch_q      <= ch_d;
      step_q    <= step_d;
      best_d_q  <= best_d_d;
      best_j_q  <= best_j_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      changed_q <= changed_d;
      iter_q    <= iter_d;
      strb_q    <= strb_d;
      cen_q     <= cen_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
    end
  end

  // Pixel buffer and label store carry no reset; contents are don't-care after abort
  always_ff @(posedge clk) begin
    if (pix_we_c) pix_mem_q[idx_q] <= Sin;
    if (lbl_we_c) label_mem_q[idx_q] <= win_j_c;
  end

  assign strb = strb_q;

endmodule

// File: tb/tb_kmeans_manhattan.sv
// Directed bench for kmeans_manhattan; results read hierarchically once strb rises.
module tb_kmeans_manhattan;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] Sin;
  logic        strb;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef KMEANS_EARLY_EXIT_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif
  localparam int BUDGET = 60000;

  kmeans_manhattan dut (
    .clk   (clk),
    .reset (reset),
    .Sin   (Sin),
    .strb  (strb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] cfg_word(input int k, input int size);
    return 24'((k << 14) | size);
  endfunction

  // Reset, release, then present the config word in the CONFIG slot
  task automatic start_run(input logic [23:0] cfg);
    reset = 1'b1;
    Sin   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    Sin = cfg;
  endtask

  task automatic load_pix(input logic [23:0] p);
    @(negedge clk);
    Sin = p;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (strb !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(strb), 32'd1);
  endtask

  initial begin
    logic [23:0] p1 [4];
    p1[0] = 24'h000000; p1[1] = 24'h000010; p1[2] = 24'hFF0000; p1[3] = 24'hFF0010;

    // Case 1: K=2, four pixels
    start_run(cfg_word(2, 4));
    check("c1_reset_strb", 32'(strb), 32'd0);
    for (int i = 0; i < 4; i++) load_pix(p1[i]);
    wait_done("c1_done");
    check("c1_cen0", 32'(dut.cen_q[0]), 32'h7F0000);
    check("c1_cen1", 32'(dut.cen_q[1]), 32'h7F0010);
    check("c1_lbl0", 32'(dut.label_mem_q[0]), 32'd0);
    check("c1_lbl1", 32'(dut.label_mem_q[1]), 32'd1);
    check("c1_lbl2", 32'(dut.label_mem_q[2]), 32'd0);
    check("c1_lbl3", 32'(dut.label_mem_q[3]), 32'd1);
    check("c1_iter", 32'(dut.iter_q), (EARLY != 0) ? 32'd2 : 32'd32);
    repeat (3) @(negedge clk);
    check("c1_strb_held", 32'(strb), 32'd1);

    // Case 2: K field 0 means 16 clusters, 16 distinct colours
    start_run(cfg_word(0, 16));
    for (int i = 0; i < 16; i++) load_pix(24'(i) * 24'h111111);
    wait_done("c2_done");
    for (int j = 0; j < 16; j++) begin
      check($sformatf("c2_cen%0d", j), 32'(dut.cen_q[j]), 32'(24'(j) * 24'h111111));
      check($sformatf("c2_lbl%0d", j), 32'(dut.label_mem_q[j]), 32'(j));
    end
    check("c2_iter", 32'(dut.iter_q), (EARLY != 0) ? 32'd1 : 32'd32);

    // Case 3: empty image goes straight to DONE
    reset = 1'b1;
    Sin   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("c3_reset_strb", 32'(strb), 32'd0);
    @(negedge clk);
    check("c3_config_strb", 32'(strb), 32'd0);
    Sin = cfg_word(2, 0);
    @(negedge clk);
    check("c3_done_strb", 32'(strb), 32'd1);
    repeat (4) @(negedge clk);
    check("c3_strb_held", 32'(strb), 32'd1);
    check("c3_iter", 32'(dut.iter_q), 32'd0);

    // Case 4: K=3 on two pixels, duplicate initial centroid stays empty
    start_run(cfg_word(3, 2));
    load_pix(24'h101010);
    load_pix(24'h202020);
    wait_done("c4_done");
    check("c4_cen0", 32'(dut.cen_q[0]), 32'h101010);
    check("c4_cen1", 32'(dut.cen_q[1]), 32'h202020);
    check("c4_cen2", 32'(dut.cen_q[2]), 32'h202020);
    check("c4_lbl0", 32'(dut.label_mem_q[0]), 32'd0);
    check("c4_lbl1", 32'(dut.label_mem_q[1]), 32'd1);
    check("c4_iter", 32'(dut.iter_q), (EARLY != 0) ? 32'd1 : 32'd32);

    // Case 5: abort in ASSIGN, then a fresh K=1 run
    start_run(cfg_word(2, 4));
    for (int i = 0; i < 4; i++) load_pix(p1[i]);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("c5_abort_strb", 32'(strb), 32'd0);
    check("c5_abort_iter", 32'(dut.iter_q), 32'd0);
    start_run(cfg_word(1, 3));
    load_pix(24'h000003);
    load_pix(24'h000006);
    load_pix(24'h000009);
    wait_done("c5_done");
    check("c5_cen0", 32'(dut.cen_q[0]), 32'h000006);
    for (int i = 0; i < 3; i++)
      check($sformatf("c5_lbl%0d", i), 32'(dut.label_mem_q[i]), 32'd0);
    check("c5_iter", 32'(dut.iter_q), (EARLY != 0) ? 32'd2 : 32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
